// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD sequencer: FSM states, HD44780 commands, display characters.
// LCD_LINE2_EN extends the refresh step range to cover the second display row.
package lcd_pkg;

    typedef enum logic [3:0] {
        PWR_WAIT, INIT_REQ, INIT_WAIT, CFG_REQ, CFG_WAIT, CLR_WAIT, IDLE, WR_REQ, WR_WAIT
    } state_t;

    typedef logic [3:0] step_t;

    localparam logic [7:0] CMD_FUNC_SET = 8'h28;
    localparam logic [7:0] CMD_ENTRY    = 8'h06;
    localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
    localparam logic [7:0] CMD_CLEAR    = 8'h01;
    localparam logic [7:0] CMD_LINE1    = 8'h80;
    localparam logic [7:0] CMD_LINE2    = 8'hC0;

    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_SHARP = 8'h23;
    localparam logic [7:0] CH_DASH  = 8'h2D;
    localparam logic [7:0] CH_LT    = 8'h3C;
    localparam logic [7:0] CH_EQ    = 8'h3D;
    localparam logic [7:0] CH_GT    = 8'h3E;

    // Steps 0..3 are the config commands, refresh starts at STEP_LINE1.
    localparam step_t STEP_CLEAR = 4'd3;
    localparam step_t STEP_LINE1 = 4'd4;
`ifdef LCD_LINE2_EN
    localparam step_t STEP_LAST  = 4'd13;
`else
    localparam step_t STEP_LAST  = 4'd8;
`endif

    function automatic logic [7:0] note_letter(input logic [3:0] n);
        case (n)
            4'd0, 4'd1:  return "C";
            4'd2, 4'd3:  return "D";
            4'd4:        return "E";
            4'd5, 4'd6:  return "F";
            4'd7, 4'd8:  return "G";
            4'd9, 4'd10: return "A";
            4'd11:       return "B";
            default:     return CH_DASH;
        endcase
    endfunction

    function automatic logic note_sharp(input logic [3:0] n);
        return (n == 4'd1) || (n == 4'd3) || (n == 4'd6) || (n == 4'd8) || (n == 4'd10);
    endfunction

    function automatic logic [7:0] indicator(input logic [1:0] t);
        case (t)
            2'b00:   return CH_EQ;
            2'b01:   return CH_LT;
            2'b10:   return CH_GT;
            default: return CH_DASH;
        endcase
    endfunction

    function automatic logic [7:0] line2_char(input logic [1:0] t, input logic [1:0] pos);
        logic [31:0] word;
        case (t)
            2'b00:   word = "OK  ";
            2'b01:   word = "FLAT";
            2'b10:   word = "SHRP";
            default: word = "----";
        endcase
        return word[8*(3-pos) +: 8];
    endfunction

endpackage

// File: rtl/lcd_sequencer_if.sv
// Handshake bus between the sequencer (master) and the lcd_physical 4-bit driver (slave).
interface lcd_sequencer_if;
    logic       phy_do_init;
    logic       phy_init_done;
    logic       phy_do_send;
    logic       phy_send_done;
    logic [7:0] phy_data;
    logic       phy_rs;

    modport master (output phy_do_init, phy_do_send, phy_data, phy_rs,
                    input  phy_init_done, phy_send_done);
    modport slave  (input  phy_do_init, phy_do_send, phy_data, phy_rs,
                    output phy_init_done, phy_send_done);
endinterface

// File: rtl/lcd_char_rom.sv
// Combinational byte table: step index plus note/tune snapshot -> {rs, data}.
// Steps 9..13 (second row) exist only with LCD_LINE2_EN.
module lcd_char_rom
    import lcd_pkg::*;
(
    input  step_t       step,
    input  logic [3:0]  note,
    input  logic [1:0]  tune,
    output logic        rs,
    output logic [7:0]  data
);
    always_comb begin
        rs   = 1'b1;
        data = CH_SPACE;
        case (step)
            4'd0: begin rs = 1'b0; data = CMD_FUNC_SET; end
            4'd1: begin rs = 1'b0; data = CMD_ENTRY;    end
            4'd2: begin rs = 1'b0; data = CMD_DISP_ON;  end
            4'd3: begin rs = 1'b0; data = CMD_CLEAR;    end
            4'd4: begin rs = 1'b0; data = CMD_LINE1;    end
            4'd5: data = note_letter(note);
            4'd6: data = note_sharp(note) ? CH_SHARP : CH_SPACE;
            4'd7: data = CH_SPACE;
            4'd8: data = indicator(tune);
`ifdef LCD_LINE2_EN
            4'd9: begin rs = 1'b0; data = CMD_LINE2; end
            // steps 10..13 map to character positions 0..3 via the low two bits
            4'd10, 4'd11, 4'd12, 4'd13: data = line2_char(tune, step[1:0] - 2'd2);
`endif
            default: ;
        endcase
    end
endmodule

// File: rtl/lcd_sequencer.sv
// Drives lcd_physical: power-up wait, init, HD44780 config, then refreshes note/tuning on update.
// Build option: LCD_LINE2_EN also writes the tuning word to the second row.
module lcd_sequencer
    import lcd_pkg::*;
#(
    parameter int POWERUP_CYC    = 750000,
    parameter int CLEAR_WAIT_CYC = 100000,
    parameter int CNT_W          = 20
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            update,
    input  logic [3:0]      note_code,
    input  logic [1:0]      tune_state,
    output logic            ready,
    lcd_sequencer_if.master phy
);
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             pending;
    step_t            step;
    logic [3:0]       note_q;
    logic [1:0]       tune_q;

    step_t            rom_step;
    logic [3:0]       rom_note;
    logic [1:0]       rom_tune;
    logic             rom_rs;
    logic [7:0]       rom_data;

    // ROM is addressed with the byte about to be issued, so data is valid in the request cycle.
    always_comb begin
        rom_step = step + 4'd1;
        rom_note = note_q;
        rom_tune = tune_q;
        case (state)
            INIT_WAIT: rom_step = '0;
            IDLE: begin
                rom_step = STEP_LINE1;
                rom_note = note_code;
                rom_tune = tune_state;
            end
            default: ;
        endcase
    end

    lcd_char_rom u_rom (
        .step (rom_step),
        .note (rom_note),
        .tune (rom_tune),
        .rs   (rom_rs),
        .data (rom_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= PWR_WAIT;
            cnt             <= '0;
            pending         <= 1'b0;
            step            <= '0;
            note_q          <= '0;
            tune_q          <= '0;
            ready           <= 1'b0;
            phy.phy_do_init <= 1'b0;
            phy.phy_do_send <= 1'b0;
            phy.phy_data    <= 8'h00;
            phy.phy_rs      <= 1'b0;
        end else begin
            phy.phy_do_init <= 1'b0;
            phy.phy_do_send <= 1'b0;
            ready           <= 1'b0;
            if (update && state != IDLE) pending <= 1'b1;
            case (state)
                PWR_WAIT: begin
                    if (cnt == CNT_W'(POWERUP_CYC)) begin
                        state           <= INIT_REQ;
                        cnt             <= '0;
                        phy.phy_do_init <= 1'b1;
                    end else cnt <= cnt + CNT_W'(1);
                end
                INIT_REQ: state <= INIT_WAIT;
                INIT_WAIT: if (phy.phy_init_done) begin
                    state           <= CFG_REQ;
                    step            <= rom_step;
                    phy.phy_data    <= rom_data;
                    phy.phy_rs      <= rom_rs;
                    phy.phy_do_send <= 1'b1;
                end
                CFG_REQ: state <= CFG_WAIT;
                CFG_WAIT: if (phy.phy_send_done) begin
                    if (step == STEP_CLEAR) state <= CLR_WAIT;
                    else begin
                        state           <= CFG_REQ;
                        step            <= rom_step;
                        phy.phy_data    <= rom_data;
                        phy.phy_rs      <= rom_rs;
                        phy.phy_do_send <= 1'b1;
                    end
                end
                CLR_WAIT: begin
                    // first IDLE entry always paints the display once
                    if (cnt == CNT_W'(CLEAR_WAIT_CYC)) begin
                        state   <= IDLE;
                        cnt     <= '0;
                        pending <= 1'b1;
                    end else cnt <= cnt + CNT_W'(1);
                end
                IDLE: begin
                    if (pending || update) begin
                        state           <= WR_REQ;
                        pending         <= 1'b0;
                        note_q          <= note_code;
                        tune_q          <= tune_state;
                        step            <= rom_step;
                        phy.phy_data    <= rom_data;
                        phy.phy_rs      <= rom_rs;
                        phy.phy_do_send <= 1'b1;
                    end else ready <= 1'b1;
                end
                WR_REQ: state <= WR_WAIT;
                WR_WAIT: if (phy.phy_send_done) begin
                    if (step == STEP_LAST) begin
                        state <= IDLE;
                        ready <= !(pending || update);
                    end else begin
                        state           <= WR_REQ;
                        step            <= rom_step;
                        phy.phy_data    <= rom_data;
                        phy.phy_rs      <= rom_rs;
                        phy.phy_do_send <= 1'b1;
                    end
                end
                default: state <= PWR_WAIT;
            endcase
        end
    end
endmodule

// File: tb/tb_lcd_sequencer.sv
// Directed bench for lcd_sequencer with a behavioural phy that answers 5 cycles after each request.
module tb_lcd_sequencer;
`ifdef LCD_LINE2_EN
    localparam bit LINE2 = 1'b1;
`else
    localparam bit LINE2 = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       update = 1'b0;
    logic [3:0] note_code = 4'd15;
    logic [1:0] tune_state = 2'd3;
    logic       ready;

    lcd_sequencer_if phy();

    lcd_sequencer #(.POWERUP_CYC(10), .CLEAR_WAIT_CYC(20), .CNT_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .update     (update),
        .note_code  (note_code),
        .tune_state (tune_state),
        .ready      (ready),
        .phy        (phy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // phy model state
    int         cyc;
    int         cd;
    int         init_cyc = -1;
    int         hold_err = 0;
    logic       is_init;
    logic [8:0] lat;
    logic       m_init_done, m_send_done;
    logic       spur_init = 1'b0, spur_send = 1'b0;
    logic [8:0] got_q[$];
    int         req_q[$];
    logic [8:0] exp_q[$];

    assign phy.phy_init_done = m_init_done | spur_init;
    assign phy.phy_send_done = m_send_done | spur_send;

    always @(posedge clk or posedge reset)
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            cd          <= 0;
            is_init     <= 1'b0;
            m_init_done <= 1'b0;
            m_send_done <= 1'b0;
        end else begin
            m_init_done <= 1'b0;
            m_send_done <= 1'b0;
            if (((cd != 0 && !is_init) || m_send_done) && {phy.phy_rs, phy.phy_data} != lat)
                hold_err <= hold_err + 1;
            if (cd == 1) begin
                if (is_init) m_init_done <= 1'b1;
                else         m_send_done <= 1'b1;
            end
            if (cd != 0) cd <= cd - 1;
            if (phy.phy_do_init) begin
                cd       <= 4;
                is_init  <= 1'b1;
                init_cyc <= cyc;
            end
            if (phy.phy_do_send) begin
                cd      <= 4;
                is_init <= 1'b0;
                lat     <= {phy.phy_rs, phy.phy_data};
                got_q.push_back({phy.phy_rs, phy.phy_data});
                req_q.push_back(cyc);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_ready(input string tag, input int lim);
        for (int i = 0; i < lim && !ready; i++) @(negedge clk);
        chk({tag, "_ready"}, ready, 1);
    endtask

    task automatic add_line(input logic [31:0] l1, input logic [31:0] l2);
        exp_q.push_back({1'b0, 8'h80});
        for (int i = 0; i < 4; i++) exp_q.push_back({1'b1, l1[8*(3-i) +: 8]});
        if (LINE2) begin
            exp_q.push_back({1'b0, 8'hC0});
            for (int i = 0; i < 4; i++) exp_q.push_back({1'b1, l2[8*(3-i) +: 8]});
        end
    endtask

    task automatic cmp_bytes(input string tag, input int b);
        chk({tag, "_count"}, got_q.size() - b, exp_q.size());
        for (int i = 0; i < exp_q.size() && b + i < got_q.size(); i++)
            chk($sformatf("%s[%0d]", tag, i), got_q[b + i], exp_q[i]);
    endtask

    task automatic boot(input string tag);
        int b, hb;
        b  = got_q.size();
        hb = hold_err;
        exp_q.delete();
        exp_q.push_back(9'h028);
        exp_q.push_back(9'h006);
        exp_q.push_back(9'h00C);
        exp_q.push_back(9'h001);
        add_line("-  -", "----");
        @(negedge clk);
        reset = 1'b0;
        wait_ready(tag, 600);
        chk({tag, "_init_cyc"}, init_cyc, 11);
        cmp_bytes(tag, b);
        if (got_q.size() >= b + 5) begin
            chk({tag, "_first_send"}, req_q[b], 17);
            chk({tag, "_cfg_gap"}, req_q[b + 1] - req_q[b], 6);
            chk({tag, "_clr_gap"}, req_q[b + 4] - req_q[b + 3], 28);
        end
        chk({tag, "_hold"}, hold_err - hb, 0);
    endtask

    task automatic refresh(input string tag, input logic [3:0] n, input logic [1:0] t,
                           input logic [31:0] l1, input logic [31:0] l2);
        int b, hb;
        b  = got_q.size();
        hb = hold_err;
        exp_q.delete();
        add_line(l1, l2);
        @(negedge clk);
        note_code  = n;
        tune_state = t;
        update     = 1'b1;
        @(posedge clk);
        #1 chk({tag, "_lat"}, {phy.phy_do_send, ready, phy.phy_rs, phy.phy_data}, {3'b100, 8'h80});
        @(negedge clk);
        update = 1'b0;
        wait_ready(tag, 400);
        cmp_bytes(tag, b);
        chk({tag, "_hold"}, hold_err - hb, 0);
    endtask

    task automatic pulse_update(input logic [3:0] n, input logic [1:0] t);
        @(negedge clk);
        note_code  = n;
        tune_state = t;
        update     = 1'b1;
        @(negedge clk);
        update = 1'b0;
    endtask

    initial begin
        int b;
        repeat (3) @(negedge clk);
        chk("reset_out", {ready, phy.phy_do_init, phy.phy_do_send, phy.phy_rs, phy.phy_data}, 12'h000);

        boot("boot");

        refresh("ref_a", 4'd9, 2'b01, "A  <", "FLAT");
        refresh("ref_fs", 4'd6, 2'b00, "F# =", "OK  ");

        // several updates during a refresh collapse into one more refresh with the last values
        b = got_q.size();
        exp_q.delete();
        add_line("D  -", "----");
        add_line("C  >", "SHRP");
        pulse_update(4'd2, 2'b11);
        repeat (3) @(negedge clk);
        pulse_update(4'd5, 2'b00);
        repeat (2) @(negedge clk);
        pulse_update(4'd7, 2'b01);
        repeat (2) @(negedge clk);
        pulse_update(4'd0, 2'b10);
        wait_ready("multi", 800);
        repeat (20) @(negedge clk);
        cmp_bytes("multi", b);
        chk("multi_ready_hold", ready, 1);

        // stray done pulses in IDLE
        b = got_q.size();
        @(negedge clk);
        spur_init = 1'b1;
        spur_send = 1'b1;
        @(negedge clk);
        spur_init = 1'b0;
        spur_send = 1'b0;
        repeat (10) @(negedge clk);
        chk("spur_sends", got_q.size() - b, 0);
        chk("spur_ready", ready, 1);

        // async reset in CFG_WAIT, then a full re-init
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        b = got_q.size();
        for (int i = 0; i < 200 && got_q.size() < b + 2; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        chk("pre_rst_data", {phy.phy_rs, phy.phy_data}, 9'h006);
        #2 reset = 1'b1;
        #1 chk("async_rst", {ready, phy.phy_do_init, phy.phy_do_send, phy.phy_rs, phy.phy_data}, 12'h000);
        repeat (2) @(negedge clk);
        note_code  = 4'd15;
        tune_state = 2'd3;
        boot("reboot");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
